// File: rtl/seq_multiplier_hs_if.sv
// Operand/product handshake bundle for seq_multiplier_hs.
// The master drives operands and out_ready. The slave (the multiplier) drives in_ready, out_valid, product and busy.
interface seq_multiplier_hs_if #(
   parameter int bitwidthA = 8,
   parameter int bitwidthB = 8
);
   logic                           in_valid;
   logic                           in_ready;
   logic                           signed_mode;
   logic [bitwidthA-1:0]           multiplicand;
   logic [bitwidthB-1:0]           multiplier;
   logic                           out_valid;
   logic                           out_ready;
   logic [bitwidthA+bitwidthB-1:0] product;
   logic                           busy;

   modport master (
      output in_valid, signed_mode, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/seq_multiplier_hs.sv
// Iterative shift-add multiplier with valid/ready handshakes and a signed/unsigned mode.
// Optional macro SEQ_MULT_EARLY_TERM_EN stops iterating once the remaining multiplier bits are zero.
module seq_multiplier_hs #(
   parameter int bitwidthA = 8,
   parameter int bitwidthB = 8,
   parameter int CNT_W     = $clog2(bitwidthB + 1)
) (
   input  logic                clock,
   input  logic                reset,
   seq_multiplier_hs_if.slave  bus
);
   localparam int PW = bitwidthA + bitwidthB;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [bitwidthA-1:0] a_mag_q, a_mag_d;
   logic [bitwidthB-1:0] b_mag_q, b_mag_d;
   logic                 neg_q, neg_d;
   logic [PW-1:0]        acc_q, acc_d;
   logic [PW-1:0]        product_q, product_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [PW-1:0]        a_shift;
   logic [bitwidthB-1:0] bit_mask;
   logic                 b_bit;
   logic                 last_iter;

   // The most negative value negates to 2^(w-1), which still fits as an unsigned w-bit magnitude.
   function automatic logic [bitwidthA-1:0] mag_a(input logic [bitwidthA-1:0] v, input logic s);
      logic signed [bitwidthA-1:0] sv;
      sv = $signed(v);
      mag_a = (s && v[bitwidthA-1]) ? $unsigned(-sv) : v;
   endfunction

   function automatic logic [bitwidthB-1:0] mag_b(input logic [bitwidthB-1:0] v, input logic s);
      logic signed [bitwidthB-1:0] sv;
      sv = $signed(v);
      mag_b = (s && v[bitwidthB-1]) ? $unsigned(-sv) : v;
   endfunction

   function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m, input logic n);
      logic signed [PW-1:0] sm;
      sm = $signed(m);
      apply_sign = n ? $unsigned(-sm) : m;
   endfunction

   assign a_shift  = PW'(a_mag_q) << cnt_q;
   assign bit_mask = bitwidthB'(1) << cnt_q;
   assign b_bit    = |(b_mag_q & bit_mask);

`ifdef SEQ_MULT_EARLY_TERM_EN
   logic b_rem_zero;
   assign b_rem_zero = ((b_mag_q >> cnt_q) == '0);
   // Bit 0 is always visited, so a zero multiplier still spends two cycles before DONE.
   assign last_iter  = (cnt_q == CNT_W'(bitwidthB)) || ((cnt_q != '0) && b_rem_zero);
`else
   assign last_iter  = (cnt_q == CNT_W'(bitwidthB));
`endif

   always_comb begin
      state_d   = state_q;
      a_mag_d   = a_mag_q;
      b_mag_d   = b_mag_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_mag_d = mag_a(bus.multiplicand, bus.signed_mode);
               b_mag_d = mag_b(bus.multiplier, bus.signed_mode);
               neg_d   = bus.signed_mode &
                         (bus.multiplicand[bitwidthA-1] ^ bus.multiplier[bitwidthB-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_iter) begin
               product_d = apply_sign(acc_q, neg_q);
               state_d   = DONE;
            end else begin
               if (b_bit) acc_d = acc_q + a_shift;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_mag_q   <= a_mag_d;
         b_mag_q   <= b_mag_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.product   = product_q;
endmodule
